// File: rtl/snake_pkg.sv
// Shared definitions for the snake playfield: cell codes, grid geometry and
// the layout of the controller's rect_write word.
package snake_pkg;

    typedef enum logic [3:0] {
        CELL_NULL  = 4'd0,
        CELL_SNAKE = 4'd1,
        CELL_ROCK  = 4'd2,
        CELL_SNACK = 4'd4
    } cell_t;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } sweep_state_t;

    localparam int GRID_SIZE_X    = 32;
    localparam int GRID_SIZE_Y    = 24;
    localparam int RECT_SIZE_LOG2 = 5;
    localparam int RECT_SIZE      = 1 << RECT_SIZE_LOG2;

    localparam int COORD_W  = 16;
    localparam int CELL_W   = 4;
    localparam int X_MSB    = 35;
    localparam int Y_MSB    = 19;
    localparam int FUNC_MSB = 3;

    // Only the four defined cell codes may be stored; anything else is noise.
    function automatic logic is_legal_func(input logic [CELL_W-1:0] func);
        logic legal;
        legal = 1'b0;
        case (func)
            CELL_NULL, CELL_SNAKE, CELL_ROCK, CELL_SNACK: legal = 1'b1;
            default:                                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/grid_ram.sv
// Distributed RAM holding one cell code per playfield cell. One synchronous
// write port, one combinational read port for the controller and one
// registered read port for the display pipeline.
module grid_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ctrl_addr,
    output logic [DATA_W-1:0] ctrl_data,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic              disp_en,
    output logic [DATA_W-1:0] disp_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage update; contents are not reset, the clear sweep fills them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Controller lookups are combinational so a collision test sees the cell at once.
    assign ctrl_data = mem[ctrl_addr];

    // Display lookup is registered; off-screen pixels read as an empty cell.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_data <= '0;
        end else if (disp_en) begin
            disp_data <= mem[disp_addr];
        end else begin
            disp_data <= '0;
        end
    end

endmodule

// File: rtl/grid_cell_memory.sv
// Playfield cell memory answering the game controller's rect read/write
// interface, feeding per-pixel cell codes to the drawing pipeline and
// clearing the field with a one-cell-per-cycle sweep.
module grid_cell_memory #(
    parameter int         GRID_SIZE_X    = 32,
    parameter int         GRID_SIZE_Y    = 24,
    parameter int         RECT_SIZE_LOG2 = 5,
    parameter bit         WALLS          = 1'b1,
    parameter logic [3:0] OOR_VALUE      = 4'b0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] rect_write,
    input  logic [31:0] rect_read_addr,
    output logic [3:0]  rect_read_data,
    input  logic        clear_req,
    output logic        busy,
    input  logic [10:0] pix_x,
    input  logic [9:0]  pix_y,
    output logic [3:0]  pix_cell
);

    import snake_pkg::*;

    localparam int X_BITS    = $clog2(GRID_SIZE_X);
    localparam int Y_BITS    = $clog2(GRID_SIZE_Y);
    localparam int ADDR_W    = X_BITS + Y_BITS;
    localparam int NUM_CELLS = GRID_SIZE_X * GRID_SIZE_Y;

    localparam logic [ADDR_W-1:0]  LAST_CELL   = ADDR_W'(NUM_CELLS - 1);
    localparam logic [COORD_W-1:0] X_LIMIT     = COORD_W'(GRID_SIZE_X);
    localparam logic [COORD_W-1:0] Y_LIMIT     = COORD_W'(GRID_SIZE_Y);
    localparam logic [X_BITS-1:0]  X_EDGE      = X_BITS'(GRID_SIZE_X - 1);
    localparam logic [Y_BITS-1:0]  Y_EDGE      = Y_BITS'(GRID_SIZE_Y - 1);
    localparam logic [10:0]        PIX_X_LIMIT = 11'(GRID_SIZE_X << RECT_SIZE_LOG2);
    localparam logic [9:0]         PIX_Y_LIMIT = 10'(GRID_SIZE_Y << RECT_SIZE_LOG2);

    sweep_state_t       state;
    logic [ADDR_W-1:0]  sweep_cnt;
    logic [35:0]        last_write;

    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic [CELL_W-1:0]  wr_func;
    logic               wr_in_grid;
    logic               ctrl_we;

    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic               rd_in_grid;
    logic [CELL_W-1:0]  ram_ctrl_data;

    logic [X_BITS-1:0]  sweep_x;
    logic [Y_BITS-1:0]  sweep_y;
    logic               sweep_on_border;
    logic [CELL_W-1:0]  sweep_data;

    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr;
    logic [CELL_W-1:0]  ram_wdata;

    logic               disp_en;
    logic [ADDR_W-1:0]  disp_addr;

    // Field extraction from the controller's write word and read address.
    assign wr_x    = rect_write[X_MSB -: COORD_W];
    assign wr_y    = rect_write[Y_MSB -: COORD_W];
    assign wr_func = rect_write[FUNC_MSB -: CELL_W];
    assign rd_x    = rect_read_addr[31:16];
    assign rd_y    = rect_read_addr[15:0];

    // Range checks run on the full 16-bit coordinates so a wrapped 16'hFFFF
    // (a step left/up from zero) lands outside the grid rather than aliasing.
    assign wr_in_grid = (wr_x < X_LIMIT) && (wr_y < Y_LIMIT);
    assign rd_in_grid = (rd_x < X_LIMIT) && (rd_y < Y_LIMIT);

    // The controller holds its write word for many cycles, so only a changed
    // word commits; bad coordinates or codes are dropped without a trace.
    assign ctrl_we = !busy && (rect_write != last_write) && wr_in_grid
                     && is_legal_func(wr_func);

    // The sweep counter doubles as the RAM address because rows are a power of two wide.
    assign sweep_x         = sweep_cnt[X_BITS-1:0];
    assign sweep_y         = sweep_cnt[ADDR_W-1:X_BITS];
    assign sweep_on_border = (sweep_x == '0) || (sweep_x == X_EDGE)
                             || (sweep_y == '0) || (sweep_y == Y_EDGE);
    assign sweep_data      = (WALLS && sweep_on_border) ? CELL_ROCK : CELL_NULL;

    // Single write port: the sweep owns it while clearing, the controller otherwise.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = sweep_cnt;
        ram_wdata = sweep_data;
        if (state == ST_CLEAR) begin
            ram_we = 1'b1;
        end else if (ctrl_we) begin
            ram_we    = 1'b1;
            ram_waddr = {wr_y[Y_BITS-1:0], wr_x[X_BITS-1:0]};
            ram_wdata = wr_func;
        end
    end

    // Sweep FSM with registered busy and the change-detect register for held writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_CLEAR;
            sweep_cnt  <= '0;
            busy       <= 1'b1;
            last_write <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    last_write <= rect_write;
                    if (clear_req) begin
                        state     <= ST_CLEAR;
                        sweep_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clear_req) begin
                        sweep_cnt <= '0;
                    end else if (sweep_cnt == LAST_CELL) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        last_write <= rect_write;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= ST_CLEAR;
                    sweep_cnt <= '0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

    // Controller reads see the RAM directly; off-grid reads look like a wall.
    assign rect_read_data = rd_in_grid ? ram_ctrl_data : OOR_VALUE;

    // Pixel to cell mapping drops the in-cell offset bits.
    assign disp_en   = (pix_x < PIX_X_LIMIT) && (pix_y < PIX_Y_LIMIT);
    assign disp_addr = {pix_y[RECT_SIZE_LOG2 +: Y_BITS], pix_x[RECT_SIZE_LOG2 +: X_BITS]};

    grid_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (CELL_W)
    ) u_grid_ram (
        .clk       (clk),
        .rst       (rst),
        .we        (ram_we),
        .waddr     (ram_waddr),
        .wdata     (ram_wdata),
        .ctrl_addr ({rd_y[Y_BITS-1:0], rd_x[X_BITS-1:0]}),
        .ctrl_data (ram_ctrl_data),
        .disp_addr (disp_addr),
        .disp_en   (disp_en),
        .disp_data (pix_cell)
    );

endmodule

// File: tb/tb_grid_cell_memory.sv
// Directed testbench for grid_cell_memory: reset sweep length and wall
// layout, controller writes and reads, range checks, held-word handling
// across a clear, sweep restart, display lookup and mid-sweep reset.
module tb_grid_cell_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] rect_write;
    logic [31:0] rect_read_addr;
    logic [3:0]  rect_read_data;
    logic        clear_req;
    logic        busy;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [3:0]  pix_cell;

    int check_count = 0;
    int error_count = 0;
    int cyc;
    int total;

    grid_cell_memory #(
        .GRID_SIZE_X    (32),
        .GRID_SIZE_Y    (24),
        .RECT_SIZE_LOG2 (5),
        .WALLS          (1'b1),
        .OOR_VALUE      (4'b0010)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rect_write     (rect_write),
        .rect_read_addr (rect_read_addr),
        .rect_read_data (rect_read_data),
        .clear_req      (clear_req),
        .busy           (busy),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .pix_cell       (pix_cell)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] wordOf(input logic [15:0] x, input logic [15:0] y,
                                           input logic [3:0] f);
        return {x, y, f};
    endfunction

    task automatic applyStimulus(input logic [35:0] wr, input logic clr);
        rect_write = wr;
        clear_req  = clr;
    endtask

    task automatic readCell(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic [3:0] expected);
        rect_read_addr = {x, y};
        #1;
        checkOutput(tag, {28'd0, rect_read_data}, {28'd0, expected});
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        rect_write     = '0;
        rect_read_addr = '0;
        clear_req      = 1'b0;
        pix_x          = '0;
        pix_y          = '0;
        #3;
        rst = 1'b0;
        repeat (3) tick();
        checkOutput("reset_busy", {31'd0, busy}, 32'd1);
        checkOutput("reset_pix_cell", {28'd0, pix_cell}, 32'd0);

        // Power-up sweep
        rst = 1'b1;
        waitIdle(cyc);
        checkOutput("reset_sweep_cycles", cyc, 32'd768);
        readCell("wall_0_5", 16'd0, 16'd5, 4'd2);
        readCell("inner_5_5", 16'd5, 16'd5, 4'd0);
        readCell("corner_31_23", 16'd31, 16'd23, 4'd2);
        readCell("wall_31_10", 16'd31, 16'd10, 4'd2);
        readCell("wall_10_0", 16'd10, 16'd0, 4'd2);
        readCell("inner_30_22", 16'd30, 16'd22, 4'd0);

        // Controller write; same-cycle read still shows the old value
        tick();
        applyStimulus(wordOf(16'd15, 16'd15, 4'h1), 1'b0);
        readCell("same_cycle_old_15_15", 16'd15, 16'd15, 4'd0);
        tick();
        checkOutput("write_15_15", {28'd0, rect_read_data}, 32'd1);

        // Out-of-grid reads
        readCell("oor_neg_x", 16'hFFFF, 16'd10, 4'd2);
        readCell("oor_x32", 16'd32, 16'd0, 4'd2);
        readCell("oor_y24", 16'd0, 16'd24, 4'd2);
        readCell("oor_neg_y", 16'd5, 16'hFFFF, 4'd2);

        // Dropped writes: off-grid aliasing onto (8,3), and an illegal code
        tick();
        applyStimulus(wordOf(16'd40, 16'd3, 4'h4), 1'b0);
        repeat (2) tick();
        readCell("drop_oor_alias_8_3", 16'd8, 16'd3, 4'd0);
        readCell("drop_oor_15_15_kept", 16'd15, 16'd15, 4'd1);
        applyStimulus(wordOf(16'd10, 16'd10, 4'h3), 1'b0);
        repeat (2) tick();
        readCell("drop_func3_10_10", 16'd10, 16'd10, 4'd0);

        // Display lookup
        applyStimulus(wordOf(16'd7, 16'd2, 4'h4), 1'b0);
        tick();
        readCell("write_snack_7_2", 16'd7, 16'd2, 4'd4);
        pix_x = 11'd160;
        pix_y = 10'd160;
        tick();
        pix_x = 11'd230;
        pix_y = 10'd70;
        #1;
        checkOutput("pix_latency_old", {28'd0, pix_cell}, 32'd0);
        tick();
        checkOutput("pix_snack_7_2", {28'd0, pix_cell}, 32'd4);
        pix_x = 11'd1100;
        tick();
        checkOutput("pix_x_oor", {28'd0, pix_cell}, 32'd0);
        pix_x = 11'd1023;
        tick();
        checkOutput("pix_right_wall", {28'd0, pix_cell}, 32'd2);
        pix_x = 11'd230;
        pix_y = 10'd767;
        tick();
        checkOutput("pix_bottom_wall", {28'd0, pix_cell}, 32'd2);
        pix_y = 10'd768;
        tick();
        checkOutput("pix_y_oor", {28'd0, pix_cell}, 32'd0);

        // Clear with a held word that changed during the sweep
        applyStimulus(wordOf(16'd7, 16'd2, 4'h4), 1'b1);
        tick();
        applyStimulus(wordOf(16'd3, 16'd3, 4'h4), 1'b0);
        checkOutput("busy_after_req", {31'd0, busy}, 32'd1);
        repeat (200) tick();
        applyStimulus(wordOf(16'd1, 16'd1, 4'h4), 1'b0);
        tick();
        readCell("busy_write_ignored_1_1", 16'd1, 16'd1, 4'd0);
        applyStimulus(wordOf(16'd3, 16'd3, 4'h4), 1'b0);
        waitIdle(cyc);
        checkOutput("clear_sweep_cycles", 201 + cyc, 32'd768);
        tick();
        readCell("held_word_not_committed_3_3", 16'd3, 16'd3, 4'd0);
        readCell("after_clear_1_1", 16'd1, 16'd1, 4'd0);
        readCell("after_clear_7_2", 16'd7, 16'd2, 4'd0);
        readCell("after_clear_15_15", 16'd15, 16'd15, 4'd0);
        applyStimulus(wordOf(16'd3, 16'd3, 4'h1), 1'b0);
        tick();
        readCell("changed_word_writes_3_3", 16'd3, 16'd3, 4'd1);

        // Sweep restart: second request 100 cycles after the first
        applyStimulus(wordOf(16'd3, 16'd3, 4'h1), 1'b1);
        tick();
        clear_req = 1'b0;
        total = 0;
        for (int i = 0; i < 99; i++) begin
            if (busy === 1'b1) total++;
            tick();
        end
        if (busy === 1'b1) total++;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        waitIdle(cyc);
        checkOutput("restart_busy_cycles", total + cyc, 32'd868);
        readCell("after_restart_3_3", 16'd3, 16'd3, 4'd0);

        // Asynchronous reset in the middle of a sweep
        pix_x = 11'd230;
        pix_y = 10'd767;
        applyStimulus(wordOf(16'd3, 16'd3, 4'h1), 1'b1);
        tick();
        clear_req = 1'b0;
        repeat (50) tick();
        checkOutput("pix_before_mid_reset", {28'd0, pix_cell}, 32'd2);
        rst = 1'b0;
        #1;
        checkOutput("mid_reset_pix_cell", {28'd0, pix_cell}, 32'd0);
        repeat (2) tick();
        checkOutput("mid_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        waitIdle(cyc);
        checkOutput("mid_reset_sweep_cycles", cyc, 32'd768);
        readCell("mid_reset_wall_0_5", 16'd0, 16'd5, 4'd2);
        readCell("mid_reset_held_3_3", 16'd3, 16'd3, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
